retire_rat: RTL and testbench

- Retirement-side register alias table (RRF) for the OOO core.
- On each ROB commit it records the committed arch→phys mapping and returns the previous physical register of that arch reg to the free list via `reg_freed` / `liberated_reg`.
- It continuously drives the full committed map, which the free list and RAT use to rebuild state on flush.
- It is the release end of the allocate/release protocol whose allocate end is the free list.

---
 rtl/retire_rat_pkg.sv | 18 +
 rtl/retire_rat.sv | 112 +++++++++++
 tb/tb_retire_rat.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/retire_rat_pkg.sv
// Shared types for the retirement-side register alias table.
package rv32i_types;

  localparam int unsigned NUM_REGS = 64;
  localparam int unsigned PHYS_W   = $clog2(NUM_REGS);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } rrf_state_t;

  typedef struct packed {
    logic              has_rd;
    logic [4:0]        arch_rd;
    logic [PHYS_W-1:0] phys_rd;
  } commit_pkt_t;

endpackage

// File: rtl/retire_rat.sv
// Retirement register alias table: records committed arch->phys mappings and
// releases the displaced phys reg. Optional check: RRF_DOUBLE_MAP_CHECK_EN.
module retire_rat #(
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned PHYS_W  = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic [4:0]           commit_arch_rd,
  input  logic [PHYS_W-1:0]    commit_phys_rd,
  input  logic                 commit_has_rd,
  output logic                 reg_freed,
  output logic [PHYS_W-1:0]    liberated_reg,
  output logic [32*PHYS_W-1:0] rrf_arch_to_physical,
`ifdef RRF_DOUBLE_MAP_CHECK_EN
  output logic                 map_error,
`endif
  output logic [CNT_W-1:0]     retire_count
);

  import rv32i_types::*;

  rrf_state_t        state_q;
  commit_pkt_t       pkt;
  logic              accept;
  logic              wr_en;
  logic [PHYS_W-1:0] map_q [1:31];
  logic [PHYS_W-1:0] map_full [32];
  logic              free_q;
  logic [PHYS_W-1:0] free_reg_q;
  logic [CNT_W-1:0]  count_q;

  assign pkt          = '{has_rd: commit_has_rd, arch_rd: commit_arch_rd, phys_rd: commit_phys_rd};
  assign commit_ready = (state_q == RUN) && !flush;
  assign accept       = commit_valid && commit_ready;
  assign wr_en        = accept && pkt.has_rd && (pkt.arch_rd != 5'd0);

  // Entry 0 is a constant zero, so only 1..31 are real flops.
  always_comb begin
    map_full[0] = '0;
    for (int unsigned i = 1; i < 32; i++) map_full[i] = map_q[i];
  end

  always_comb begin
    rrf_arch_to_physical = '0;
    for (int unsigned i = 0; i < 32; i++)
      rrf_arch_to_physical[i*PHYS_W +: PHYS_W] = map_full[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (flush) state_q <= HOLD;
        HOLD:    state_q <= flush ? HOLD : RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < 32; i++) map_q[i] <= PHYS_W'(i);
      free_q     <= 1'b0;
      free_reg_q <= '0;
      count_q    <= '0;
    end else begin
      free_q <= wr_en;
      if (wr_en) begin
        free_reg_q          <= map_full[pkt.arch_rd];
        map_q[pkt.arch_rd]  <= pkt.phys_rd;
      end
      if (accept) count_q <= count_q + CNT_W'(1);
    end
  end

  // A release that lands on a flush is dropped; the rebuild uses the map.
  assign reg_freed     = free_q && !flush;
  assign liberated_reg = free_reg_q;
  assign retire_count  = count_q;

`ifdef RRF_DOUBLE_MAP_CHECK_EN
  logic [NUM_REGS-1:0] in_map_q;
  logic                map_err_q;
  logic                dup_hit;

  assign dup_hit = accept && pkt.has_rd &&
                   (in_map_q[pkt.phys_rd] || ((pkt.phys_rd == '0) && (pkt.arch_rd != 5'd0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) in_map_q[i] <= (i < 32);
      map_err_q <= 1'b0;
    end else begin
      if (dup_hit) map_err_q <= 1'b1;
      // Clear the displaced reg first so a same-reg rewrite keeps its bit.
      if (wr_en) begin
        in_map_q[map_full[pkt.arch_rd]] <= 1'b0;
        in_map_q[pkt.phys_rd]           <= 1'b1;
      end
    end
  end

  assign map_error = map_err_q;
`endif

endmodule

// File: tb/tb_retire_rat.sv
// Directed self-checking bench for retire_rat (RRF_DOUBLE_MAP_CHECK_EN optional).
module tb_retire_rat;

  localparam int unsigned PW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           commit_valid;
  logic           commit_ready;
  logic [4:0]     commit_arch_rd;
  logic [PW-1:0]  commit_phys_rd;
  logic           commit_has_rd;
  logic           reg_freed;
  logic [PW-1:0]  liberated_reg;
  logic [32*PW-1:0] rrf;
  logic [31:0]    retire_count;
`ifdef RRF_DOUBLE_MAP_CHECK_EN
  logic           map_error;
`endif

  int checks = 0;
  int errors = 0;

  retire_rat #(.NUM_REGS(64), .CNT_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .commit_valid         (commit_valid),
    .commit_ready         (commit_ready),
    .commit_arch_rd       (commit_arch_rd),
    .commit_phys_rd       (commit_phys_rd),
    .commit_has_rd        (commit_has_rd),
    .reg_freed            (reg_freed),
    .liberated_reg        (liberated_reg),
    .rrf_arch_to_physical (rrf),
`ifdef RRF_DOUBLE_MAP_CHECK_EN
    .map_error            (map_error),
`endif
    .retire_count         (retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] map_at(input int unsigned a);
    return 32'(rrf[a*PW +: PW]);
  endfunction

  // Advance one active edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic hr, input logic [4:0] a, input logic [PW-1:0] p);
    commit_valid   = v;
    commit_has_rd  = hr;
    commit_arch_rd = a;
    commit_phys_rd = p;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, '0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) chk($sformatf("reset_map%0d", i), map_at(i), 32'(i));
    chk("reset_freed", 32'(reg_freed), 0);
    chk("reset_count", retire_count, 0);
    chk("reset_ready", 32'(commit_ready), 1);
    chk("reset_lib", 32'(liberated_reg), 0);
`ifdef RRF_DOUBLE_MAP_CHECK_EN
    chk("reset_maperr", 32'(map_error), 0);
`endif

    // Single release
    drive(1'b1, 1'b1, 5'd5, 6'd40);
    step();
    drive(1'b0, 1'b0, 5'd0, '0);
    chk("single_freed", 32'(reg_freed), 1);
    chk("single_lib", 32'(liberated_reg), 5);
    chk("single_map5", map_at(5), 40);
    chk("single_count", retire_count, 1);
    step();
    chk("single_freed_after", 32'(reg_freed), 0);

    // Reset discards an in-flight release and restores identity map
    drive(1'b1, 1'b1, 5'd10, 6'd20);
    step();
    drive(1'b0, 1'b0, 5'd0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_freed", 32'(reg_freed), 0);
    chk("midrst_lib", 32'(liberated_reg), 0);
    chk("midrst_map10", map_at(10), 10);
    chk("midrst_map5", map_at(5), 5);
    chk("midrst_count", retire_count, 0);

    // Chained commits to the same arch reg
    drive(1'b1, 1'b1, 5'd5, 6'd41);
    step();
    drive(1'b1, 1'b1, 5'd5, 6'd42);
    chk("chain1_freed", 32'(reg_freed), 1);
    chk("chain1_lib", 32'(liberated_reg), 5);
    step();
    drive(1'b0, 1'b0, 5'd0, '0);
    chk("chain2_freed", 32'(reg_freed), 1);
    chk("chain2_lib", 32'(liberated_reg), 41);
    chk("chain_map5", map_at(5), 42);
    chk("chain_count", retire_count, 2);
    step();
    chk("chain_freed_after", 32'(reg_freed), 0);

    // x0 and no-rd commits
    drive(1'b1, 1'b1, 5'd0, 6'd33);
    step();
    drive(1'b1, 1'b0, 5'd9, 6'd50);
    chk("x0_freed", 32'(reg_freed), 0);
    chk("x0_map0", map_at(0), 0);
    step();
    drive(1'b0, 1'b0, 5'd0, '0);
    chk("nord_freed", 32'(reg_freed), 0);
    chk("nord_map9", map_at(9), 9);
    chk("nord_count", retire_count, 4);

    // Flush: release suppressed, HOLD blocks commits for one cycle
    drive(1'b1, 1'b1, 5'd7, 6'd50);
    step();
    drive(1'b0, 1'b0, 5'd0, '0);
    flush = 1'b1;
    #1;
    chk("flush_freed", 32'(reg_freed), 0);
    chk("flush_ready", 32'(commit_ready), 0);
    chk("flush_map7", map_at(7), 50);
    step();
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd8, 6'd60);
    #1;
    chk("hold_ready", 32'(commit_ready), 0);
    step();
    drive(1'b0, 1'b0, 5'd0, '0);
    chk("run_ready", 32'(commit_ready), 1);
    chk("hold_map8", map_at(8), 8);
    chk("hold_freed", 32'(reg_freed), 0);
    chk("flush_count", retire_count, 5);
    chk("flush_map7_kept", map_at(7), 50);

`ifdef RRF_DOUBLE_MAP_CHECK_EN
    drive(1'b1, 1'b1, 5'd3, 6'd4);
    step();
    drive(1'b0, 1'b0, 5'd0, '0);
    chk("dup_maperr", 32'(map_error), 1);
    chk("dup_map3", map_at(3), 4);
    step();
    step();
    chk("dup_sticky", 32'(map_error), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("dup_cleared", 32'(map_error), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
